// File: rtl/red_iterativa_serial_if.sv
// Operand/result bundle for the bit-serial iterative network.
// The master drives the operands and start; the slave returns status and the boundary X/Y pair.
interface red_iterativa_serial_if #(
    parameter int N     = 8,
    parameter int CNT_W = 4
);
    logic             start;
    logic [N-1:0]     a_word;
    logic [N-1:0]     b_word;
    logic             busy;
    logic             done;
    logic             X;
    logic             Y;
    logic [CNT_W-1:0] cell_idx;

    modport master (
        output start, a_word, b_word,
        input  busy, done, X, Y, cell_idx
    );

    modport slave (
        input  start, a_word, b_word,
        output busy, done, X, Y, cell_idx
    );
endinterface

// File: rtl/red_iterativa_serial.sv
// Bit-serial left-to-right iterative network: walks one cell per clock from the MSB to the LSB.
// The X/Y pair left after cell 0 feeds the final cell, which computes Z = ~X.
module red_iterativa_serial #(
    parameter int N     = 8,
    parameter int CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    red_iterativa_serial_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic             x_q, x_d;
    logic             y_q, y_d;
    logic [CNT_W-1:0] idx_q, idx_d;

    // Selected cell's pair-enable; a one-hot mask avoids an index wider than the word.
    logic [N-1:0] e_bits;
    logic         e;

    assign e_bits = a_q & b_q;
    assign e      = |(e_bits & (N'(1) << idx_q));

    // NOTE: every next-state value gets a default first, so no path through the case leaves one unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        x_d     = x_q;
        y_d     = y_q;
        idx_d   = idx_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a_word;
                    b_d     = bus.b_word;
                    x_d     = 1'b0;
                    y_d     = 1'b0;
                    idx_d   = CNT_W'(N - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                x_d = x_q | (y_q & e);
                y_d = e;
                if (idx_q == '0) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            x_q     <= x_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.busy     = (state_q == RUN) || (state_q == DONE);
    assign bus.done     = (state_q == DONE);
    assign bus.X        = x_q;
    assign bus.Y        = y_q;
    assign bus.cell_idx = idx_q;

endmodule

// File: tb/tb_red_iterativa_serial.sv
// Directed bench for red_iterativa_serial (N=8): checks status timing, cell walk and X/Y results
// against hand-computed values, including ignored mid-run start and mid-run reset.
module tb_red_iterativa_serial;

    localparam int N     = 8;
    localparam int CNT_W = 4;

    logic clk;
    logic reset;

    int n_checks = 0;
    int n_fail   = 0;

    red_iterativa_serial_if #(.N(N), .CNT_W(CNT_W)) bus ();

    red_iterativa_serial #(.N(N), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Start one evaluation from a negedge in IDLE; returns at the negedge after edge t0+N+1 (IDLE again),
    // so a following call places its start at edge t0+N+2.
    // inject: 0 none, 1 extra start plus a_word change sampled at t0+3, 2 reset sampled at t0+4.
    task automatic eval(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic exp_x, input logic exp_y, input int inject);
        int       done_cnt;
        logic     ex_busy, ex_done, ex_x, ex_y;
        logic [CNT_W-1:0] ex_idx;
        bit       killed;
        done_cnt       = 0;
        killed         = 0;
        bus.start      = 1'b1;
        bus.a_word     = a;
        bus.b_word     = b;
        @(posedge clk);
        for (int k = 1; k <= N + 2; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            if (inject == 2 && k == 5) killed = 1;
            if (killed) begin
                ex_busy = 1'b0;
                ex_done = 1'b0;
                ex_idx  = '0;
            end else begin
                ex_busy = (k <= N + 1);
                ex_done = (k == N + 1);
                ex_idx  = (k <= N) ? CNT_W'(N - k) : '0;
            end
            if (bus.done) done_cnt++;
            check($sformatf("%s_k%0d_busy_done_idx", name, k),
                  {26'd0, bus.busy, bus.done, bus.cell_idx},
                  {26'd0, ex_busy, ex_done, ex_idx});
            if (killed) begin
                check($sformatf("%s_k%0d_xy_cleared", name, k), {30'd0, bus.X, bus.Y}, 32'd0);
            end
            if (inject == 1 && k == 3) begin
                bus.start  = 1'b1;
                bus.a_word = '0;
            end
            if (inject == 1 && k == 4) bus.start = 1'b0;
            if (inject == 2 && k == 4) reset = 1'b1;
            if (inject == 2 && k == 5) reset = 1'b0;
        end
        ex_x = killed ? 1'b0 : exp_x;
        ex_y = killed ? 1'b0 : exp_y;
        check({name, "_xy"}, {30'd0, bus.X, bus.Y}, {30'd0, ex_x, ex_y});
        check({name, "_done_pulses"}, done_cnt, killed ? 0 : 1);
    endtask

    initial begin
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.a_word = '0;
        bus.b_word = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("idle_reset_c%0d", c),
                  {25'd0, bus.X, bus.Y, bus.busy, bus.done, bus.cell_idx}, 32'd0);
        end

        // e = C0: cells 7 and 6 adjacent -> X=1, last e0=0 -> Y=0
        eval("c0_ff", 8'hC0, 8'hFF, 1'b1, 1'b0, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("hold_c0_c%0d", c), {29'd0, bus.X, bus.Y, bus.busy}, {29'd0, 1'b1, 1'b0, 1'b0});
        end

        // e = AA: no adjacent pair -> X=0, Y=0
        eval("aa_ff", 8'hAA, 8'hFF, 1'b0, 1'b0, 0);
        // e = 81 -> X=0, Y=1
        eval("ff_81", 8'hFF, 8'h81, 1'b0, 1'b1, 0);
        // e = FF -> X=1, Y=1
        eval("ff_ff", 8'hFF, 8'hFF, 1'b1, 1'b1, 0);

        // e = 03 -> X=1, Y=1; ignored start and a_word change mid-run
        eval("mid_start", 8'h03, 8'h03, 1'b1, 1'b1, 1);
        // back-to-back start at t0+N+2; e = 04 -> X=0, Y=0
        eval("b2b", 8'h0C, 8'h04, 1'b0, 1'b0, 0);

        // reset at t0+4 aborts; then e = 18 -> X=1, Y=0
        eval("rst_mid", 8'hFF, 8'hFF, 1'b1, 1'b1, 2);
        eval("after_rst", 8'h18, 8'h18, 1'b1, 1'b0, 0);

        // reset together with start: start dropped
        reset      = 1'b1;
        bus.start  = 1'b1;
        bus.a_word = 8'hFF;
        bus.b_word = 8'hFF;
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("rst_with_start", {25'd0, bus.X, bus.Y, bus.busy, bus.done, bus.cell_idx}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
